// File: rtl/cache_pkg.sv
// Shared types and constants for the data-cache
// memory side (line buffer, burst beats, adapter FSM).
package cache_pkg;

  localparam int LINE_W      = 256;
  localparam int BEAT_W      = 64;
  localparam int BEATS       = LINE_W / BEAT_W;
  localparam int OFFSET_BITS = 5;

  typedef logic [LINE_W-1:0] line_t;
  typedef logic [BEAT_W-1:0] beat_t;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_CMD  = 3'd1,
    RD_DATA = 3'd2,
    WR_DATA = 3'd3,
    RESP    = 3'd4
  } adapter_state_t;

endpackage

// File: rtl/cacheline_adapter.sv
// Line-to-burst adapter: turns one 256-bit cache line
// request into a 4-beat 64-bit burst and back.
module cacheline_adapter
  import cache_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       dfp_addr,
  input  logic              dfp_read,
  input  logic              dfp_write,
  input  logic [LINE_W-1:0] dfp_wdata,
  output logic [LINE_W-1:0] dfp_rdata,
  output logic              dfp_resp,
  output logic [31:0]       bmem_addr,
  output logic              bmem_read,
  output logic              bmem_write,
  output logic [BEAT_W-1:0] bmem_wdata,
  input  logic              bmem_ready,
  input  logic [31:0]       bmem_raddr,
  input  logic [BEAT_W-1:0] bmem_rdata,
  input  logic              bmem_rvalid
);

  adapter_state_t state_q, state_d;
  logic [1:0]     cnt_q;
  line_t          line_q;
  line_t          rdata_q;
  logic [31:0]    addr_q;
  logic [31:0]    line_addr;
  logic           beat_ok;
  logic           unused_offset;

  assign line_addr = {dfp_addr[31:OFFSET_BITS],
                      {OFFSET_BITS{1'b0}}};
  assign unused_offset = ^dfp_addr[OFFSET_BITS-1:0];
  assign beat_ok = bmem_rvalid &&
                   (bmem_raddr == addr_q);

  // Next state and Moore outputs; strobes depend on state only.
  always_comb begin
    state_d    = state_q;
    bmem_read  = 1'b0;
    bmem_write = 1'b0;
    bmem_addr  = '0;
    bmem_wdata = '0;
    dfp_resp   = 1'b0;
    dfp_rdata  = rdata_q;
    unique case (state_q)
      IDLE: begin
        if (dfp_write)
          state_d = WR_DATA;
        else if (dfp_read)
          state_d = RD_CMD;
      end
      RD_CMD: begin
        bmem_read = 1'b1;
        bmem_addr = addr_q;
        if (bmem_ready)
          state_d = RD_DATA;
      end
      RD_DATA: begin
        if (beat_ok && cnt_q == 2'd3)
          state_d = RESP;
      end
      WR_DATA: begin
        bmem_write = 1'b1;
        bmem_addr  = addr_q;
        bmem_wdata = line_q[{cnt_q, 6'b0} +: BEAT_W];
        if (bmem_ready && cnt_q == 2'd3)
          state_d = RESP;
      end
      RESP: begin
        dfp_resp  = 1'b1;
        dfp_rdata = line_q;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, address latch, beat counter and line buffer.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      line_q  <= '0;
      rdata_q <= '0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      unique case (state_q)
        IDLE: begin
          if (dfp_write) begin
            addr_q <= line_addr;
            line_q <= dfp_wdata;
            cnt_q  <= '0;
          end else if (dfp_read) begin
            addr_q <= line_addr;
            cnt_q  <= '0;
          end
        end
        RD_DATA: begin
          if (beat_ok) begin
            line_q[{cnt_q, 6'b0} +: BEAT_W] <= bmem_rdata;
            cnt_q <= cnt_q + 2'd1;
          end
        end
        WR_DATA: begin
          if (bmem_ready)
            cnt_q <= cnt_q + 2'd1;
        end
        RESP: rdata_q <= line_q;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cacheline_adapter.sv
// Bench for cacheline_adapter: a burst-memory model
// plus directed and random line transactions.
module tb_cacheline_adapter;

  typedef logic [255:0] line_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [31:0]  dfp_addr = '0;
  logic         dfp_read = 1'b0;
  logic         dfp_write = 1'b0;
  line_t        dfp_wdata = '0;
  line_t        dfp_rdata;
  logic         dfp_resp;
  logic [31:0]  bmem_addr;
  logic         bmem_read;
  logic         bmem_write;
  logic [63:0]  bmem_wdata;
  logic         bmem_ready = 1'b0;
  logic [31:0]  bmem_raddr = '0;
  logic [63:0]  bmem_rdata = '0;
  logic         bmem_rvalid = 1'b0;

  int checks = 0;
  int errors = 0;
  int resp_n = 0;

  line_t mem [logic [31:0]];

  cacheline_adapter dut (
    .clk         (clk),
    .rst         (rst),
    .dfp_addr    (dfp_addr),
    .dfp_read    (dfp_read),
    .dfp_write   (dfp_write),
    .dfp_wdata   (dfp_wdata),
    .dfp_rdata   (dfp_rdata),
    .dfp_resp    (dfp_resp),
    .bmem_addr   (bmem_addr),
    .bmem_read   (bmem_read),
    .bmem_write  (bmem_write),
    .bmem_wdata  (bmem_wdata),
    .bmem_ready  (bmem_ready),
    .bmem_raddr  (bmem_raddr),
    .bmem_rdata  (bmem_rdata),
    .bmem_rvalid (bmem_rvalid)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    if (!rst && dfp_resp) resp_n++;

  task automatic chk(input string tag,
                     input logic [255:0] obs,
                     input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  function automatic line_t rand_line();
    line_t l;
    for (int i = 0; i < 8; i++)
      l[32*i +: 32] = $urandom;
    return l;
  endfunction

  function automatic logic [31:0] laddr(input logic [31:0] a);
    return {a[31:5], 5'b0};
  endfunction

  task automatic idle_bus();
    bmem_ready  = 1'b0;
    bmem_rvalid = 1'b0;
    bmem_raddr  = '0;
    bmem_rdata  = '0;
  endtask

  // Memory side of a line read. stall: ready-low cycles
  // on the command; gaps: random rvalid holes; stray:
  // holes may carry a beat tagged for another line.
  task automatic do_read(input logic [31:0] a, input int stall,
                         input bit gaps, input bit stray,
                         input int lat);
    logic [31:0] la;
    line_t exp;
    int beats, cyc;
    bit cmd, done;
    la = laddr(a);
    beats = 0; cyc = 0; cmd = 0; done = 0;
    if (!mem.exists(la)) mem[la] = rand_line();
    exp = mem[la];
    dfp_addr = a; dfp_read = 1'b1; dfp_write = 1'b0;
    while (!done && cyc < 100) begin
      @(negedge clk);
      cyc++;
      idle_bus();
      if (bmem_write) chk("rd_no_write", bmem_write, 0);
      if (dfp_resp) begin
        chk("rd_line", dfp_rdata, exp);
        chk("rd_beats", beats, 4);
        if (lat > 0) chk("rd_latency", cyc, lat);
        done = 1;
        dfp_read = 1'b0;
      end else if (bmem_read) begin
        chk("rd_single_cmd", cmd, 0);
        chk("rd_cmd_addr", bmem_addr, la);
        if (stall > 0) stall--;
        else begin
          bmem_ready = 1'b1;
          cmd = 1;
        end
      end else if (cmd && beats < 4) begin
        if (gaps && $urandom_range(0, 1) == 0) begin
          if (stray && $urandom_range(0, 1) == 1) begin
            bmem_rvalid = 1'b1;
            bmem_raddr  = la ^ 32'h100;
            bmem_rdata  = {$urandom, $urandom};
          end
        end else begin
          bmem_rvalid = 1'b1;
          bmem_raddr  = la;
          bmem_rdata  = exp[64*beats +: 64];
          beats++;
        end
      end
    end
    chk("rd_done", done, 1);
  endtask

  // Memory side of a line write. pat/plen give a directed
  // ready pattern for the first plen beat cycles.
  task automatic do_write(input logic [31:0] a, input line_t l,
                          input logic [15:0] pat, input int plen,
                          input int lat);
    logic [31:0] la;
    int beats, cyc, idx;
    bit done;
    la = laddr(a);
    beats = 0; cyc = 0; idx = 0; done = 0;
    dfp_addr = a; dfp_wdata = l;
    dfp_write = 1'b1; dfp_read = 1'b0;
    while (!done && cyc < 100) begin
      @(negedge clk);
      cyc++;
      idle_bus();
      if (bmem_read) chk("wr_no_read", bmem_read, 0);
      if (dfp_resp) begin
        chk("wr_resp_line", dfp_rdata, l);
        chk("wr_beats", beats, 4);
        if (lat > 0) chk("wr_latency", cyc, lat);
        done = 1;
        dfp_write = 1'b0;
        mem[la] = l;
      end else if (bmem_write) begin
        chk("wr_addr", bmem_addr, la);
        if (beats < 4)
          chk("wr_data", bmem_wdata, l[64*beats +: 64]);
        else
          chk("wr_extra_beat", beats, 3);
        if (idx < plen) bmem_ready = pat[idx];
        else bmem_ready = 1'($urandom_range(0, 1));
        idx++;
        if (bmem_ready) beats++;
      end
    end
    chk("wr_done", done, 1);
  endtask

  initial begin
    line_t l;
    int r0, beats;
    logic [31:0] a;

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_resp", dfp_resp, 0);
    chk("rst_read", bmem_read, 0);
    chk("rst_write", bmem_write, 0);
    chk("rst_addr", bmem_addr, 0);
    chk("rst_wdata", bmem_wdata, 0);
    chk("rst_rdata", dfp_rdata, 0);
    rst = 1'b0;

    // read, no stalls
    mem[32'h0000_1220] = {{16{4'h4}}, {16{4'h3}},
                          {16{4'h2}}, {16{4'h1}}};
    do_read(32'h0000_1234, 0, 0, 0, 6);
    @(negedge clk);

    // write, ready pattern 1,0,1,1,0,1
    l = {{16{4'hD}}, {16{4'hC}}, {16{4'hB}}, {16{4'hA}}};
    do_write(32'h8000_0040, l, 16'b10_1101, 6, 0);
    @(negedge clk);
    chk("wr_write_low", bmem_write, 0);
    chk("wr_resp_low", dfp_resp, 0);

    // write-back then allocate, back to back
    r0 = resp_n;
    do_write(32'h0000_2000, rand_line(), 16'hFFFF, 4, 5);
    do_read(32'h0000_3000, 0, 0, 0, 7);
    @(negedge clk);
    chk("wb_alloc_resps", resp_n, r0 + 2);

    // command stall and beat gaps
    do_read(32'h4444_0008, 3, 1, 0, 0);
    @(negedge clk);

    // stray beats with a foreign line tag
    do_read(32'h5000_0060, 0, 1, 1, 0);
    @(negedge clk);

    // reset after two accepted write beats
    r0 = resp_n;
    a = 32'h0000_7000;
    dfp_addr = a; dfp_wdata = rand_line();
    dfp_write = 1'b1;
    beats = 0;
    for (int c = 0; c < 20 && beats < 2; c++) begin
      @(negedge clk);
      idle_bus();
      if (bmem_write) begin
        bmem_ready = 1'b1;
        beats++;
      end
    end
    @(negedge clk);
    idle_bus();
    rst = 1'b1;
    dfp_write = 1'b0;
    bmem_rvalid = 1'b1;
    bmem_raddr = a;
    @(negedge clk);
    chk("abort_write", bmem_write, 0);
    chk("abort_read", bmem_read, 0);
    chk("abort_resp", dfp_resp, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("abort_idle_rvalid", bmem_read, 0);
    idle_bus();
    chk("abort_no_resp", resp_n, r0);
    do_read(32'h0000_8000, 0, 0, 0, 6);
    @(negedge clk);

    // random traffic, sometimes back to back
    for (int t = 0; t < 24; t++) begin
      a = $urandom_range(0, 15) << 5;
      a = a | $urandom_range(0, 31);
      if ($urandom_range(0, 1) == 1)
        do_write(a, rand_line(), 16'h0, 0, 0);
      else
        do_read(a, $urandom_range(0, 3), 1, 1, 0);
      if ($urandom_range(0, 1) == 1) @(negedge clk);
    end
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/cacheline_adapter.md
Name: cacheline_adapter

Overview:
- Downstream neighbour of the data cache.
- Converts the cache's 256-bit line-granular read/write request (dfp_* side) into a 4-beat, 64-bit burst transaction on the burst-memory interface (bmem_* side).
- Reads: collects the returned beats into one line. Writes: serialises the evicted line.
- Returns a single-cycle dfp_resp to the cache in both cases.

Parameters:
- LINE_W, 256, cache line width in bits.
- BEAT_W, 64, burst-memory data width in bits.
- BEATS, LINE_W/BEAT_W (4), beats per line. Derived; must not be overridden independently.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- dfp_addr  in  32  line request address; bits [4:0] ignored
- dfp_read  in  1  line read request; held high by the cache until dfp_resp
- dfp_write  in  1  line write request; held high by the cache until dfp_resp
- dfp_wdata  in  256  line to write; valid while dfp_write is high
- dfp_rdata  out  256  assembled read line; valid in the dfp_resp cycle
- dfp_resp  out  1  one-cycle completion pulse
- bmem_addr  out  32  burst line address, {dfp_addr[31:5],5'b0}
- bmem_read  out  1  burst read command (one cycle, accepted when bmem_ready)
- bmem_write  out  1  burst write beat strobe
- bmem_wdata  out  64  write beat data
- bmem_ready  in  1  memory accepts the command/beat this cycle
- bmem_raddr  in  32  line address tag of the returning read beat
- bmem_rdata  in  64  read beat data
- bmem_rvalid  in  1  read beat valid

Behaviour:
- Reset (synchronous): state=IDLE; beat counter=0; line buffer=0; latched address=0.
  - Reset output values: dfp_resp=0, bmem_read=0, bmem_write=0, bmem_addr=0, bmem_wdata=0, dfp_rdata=0.
- States: IDLE, RD_CMD, RD_DATA, WR_DATA, RESP.
- IDLE:
  - If dfp_write=1: latch the line address and dfp_wdata, clear the counter, go to WR_DATA.
  - Else if dfp_read=1: latch the address, clear the counter, go to RD_CMD.
  - dfp_read and dfp_write high together is illegal for the cache; write wins.
  - bmem_rvalid in IDLE is ignored.
- RD_CMD:
  - Drive bmem_read=1 and bmem_addr=latched address.
  - Hold both until bmem_ready=1, then go to RD_DATA.
- RD_DATA:
  - A beat counts only when bmem_rvalid=1 and bmem_raddr equals the latched address; otherwise it is dropped.
  - Beat i is written to line[64*i +: 64]; the counter increments and wraps 3->0.
  - On the accepted beat with counter=3, go to RESP.
  - Beats may be non-contiguous; gaps in rvalid simply stall.
- WR_DATA:
  - Drive bmem_write=1, bmem_addr=latched address, bmem_wdata=line[64*counter +: 64].
  - The counter advances only in cycles with bmem_ready=1. bmem_write stays high through ready-low stalls; bmem_wdata stays stable.
  - After the beat with counter=3 is accepted, go to RESP.
- RESP:
  - dfp_resp=1 for exactly one cycle; dfp_rdata=line buffer (for a write, the written line), then IDLE.
  - The request must not be re-sampled in the RESP cycle.
  - A request seen in the cycle after RESP is a new transaction. This is required for the cache's write-back -> allocate sequence: dfp_write drops and dfp_read rises the cycle after resp.
- Latency:
  - Read: 1 (IDLE) + command stall + beat arrival + 1 (RESP) cycles. Minimum, with ready and rvalid immediate: IDLE(1), RD_CMD(1), RD_DATA(4), RESP(1) = 7 cycles from request to resp.
  - Write minimum: IDLE(1), WR_DATA(4), RESP(1) = 6 cycles.
- dfp_rdata holds its last value outside RESP; consumers use it only when dfp_resp=1.
- Reset mid-operation: the state machine aborts to IDLE and all strobes drop in the cycle after reset is sampled. Late read beats after reset are ignored in IDLE.
- Address: bits [4:0] are always forced to zero on bmem_addr.

Decomposition:
- Shared package cache_pkg:
  - constants LINE_W, BEAT_W, BEATS, OFFSET_BITS=5;
  - typedef line_t (logic [255:0]) and beat_t (logic [63:0]);
  - enum adapter_state_t.
- No sub-module needed. The line buffer and beat counter are inline registers; the state machine is one always_ff for registers plus one always_comb for next-state and outputs.

Test Plan:
- Read, no stalls: dfp_read, addr 0x0000_1234. Expect bmem_read with addr 0x0000_1220 for 1 cycle. Then return beats 0x11..11, 0x22..22, 0x33..33, 0x44..44 on consecutive cycles. Expect dfp_resp one cycle later with dfp_rdata={0x44..44,0x33..33,0x22..22,0x11..11}.
- Write with ready stalls: dfp_write, addr 0x8000_0040, wdata beats A,B,C,D; bmem_ready pattern 1,0,1,1,0,1. Expect bmem_wdata sequence A,B,B,C,D,D; dfp_resp after the 4th accepted beat; bmem_write low afterwards.
- Write-back then allocate: write completes, and dfp_read is raised the very next cycle. Expect no dropped or merged transaction, a new bmem_read issued, and exactly two dfp_resp pulses.
- Read, command stall and beat gaps: bmem_ready low for 3 cycles in RD_CMD, then rvalid with gaps. Expect bmem_read held with a constant addr, correct line assembly, and a single resp.
- Stray beat: rvalid with bmem_raddr≠latched address during RD_DATA. Expect it ignored and the line unchanged.
- Reset mid-write after 2 beats: expect bmem_write=0 and state IDLE next cycle, no dfp_resp; a subsequent read completes normally.
